sevensegment_scanner: RTL and testbench

Multiplexed driver for a bank of common-cathode seven-segment digits sharing one segment bus. It takes a packed multi-digit hex value, buffers it, and applies it only at frame boundaries so the display never tears. It time-slices the digits with a programmable dwell and an anti-ghosting guard interval. It sits between the datapath's display value and the board pins, and reuses the team's existing hex-to-segment table for each digit.

---
 rtl/sevseg_pkg.sv | 29 ++
 rtl/sevensegmentdecoder.sv | 37 +++
 rtl/sevensegment_scanner.sv | 184 ++++++++++++++++++
 tb/tb_sevensegment_scanner.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sevseg_pkg.sv
// -----------------------------------------------------------------------------
// sevseg_pkg
// Shared definitions for the seven-segment scanner and its decoder:
//   - segment bit positions on the 8-bit segment bus (dp, g..a)
//   - the all-dark segment pattern
//   - one-hot digit-select helper
// -----------------------------------------------------------------------------
package sevseg_pkg;

    localparam int unsigned MAX_DIGITS = 8;

    // Segment bus bit positions (active-high, common-cathode)
    localparam int unsigned SEG_DP = 7;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_F  = 5;
    localparam int unsigned SEG_E  = 4;
    localparam int unsigned SEG_D  = 3;
    localparam int unsigned SEG_C  = 2;
    localparam int unsigned SEG_B  = 1;
    localparam int unsigned SEG_A  = 0;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    // One-hot digit select for a digit index (widest supported bank)
    function automatic logic [MAX_DIGITS-1:0] onehot_idx(input logic [2:0] idx);
        onehot_idx = 8'b0000_0001 << idx;
    endfunction

endpackage

// File: rtl/sevensegmentdecoder.sv
// -----------------------------------------------------------------------------
// sevensegmentdecoder
// Hex nibble to seven-segment glyph (gfedcba, active-high).
// Ports:
//   hex  in  4  nibble to display
//   seg  out 7  segment pattern, bit 6 = g ... bit 0 = a
// -----------------------------------------------------------------------------
module sevensegmentdecoder (
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Glyph lookup for 0-9, A, b, C, d, E, F
    always_comb begin
        seg = 7'h00;
        case (hex)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            4'hF:    seg = 7'h71;
            default: seg = 7'h00;
        endcase
    end

endmodule

// File: rtl/sevensegment_scanner.sv
// -----------------------------------------------------------------------------
// sevensegment_scanner
// Time-multiplexed driver for DIGITS common-cathode seven-segment digits on a
// shared segment bus. A loaded value waits in a pending buffer and is moved to
// the display register only when the scan wraps back to digit 0, so a frame is
// never shown half-old / half-new. Each digit slot lasts PRESCALE cycles, the
// first GUARD of which keep every digit dark to avoid ghosting.
//
// Optional build macro:
//   SEVSEG_BLANK_EN  leading-zero blanking (digit 0 never blanked, dp kept)
//
// Ports:
//   clk          in   1          rising-edge clock
//   rst_n        in   1          synchronous active-low reset
//   enable       in   1          scan enable; low holds the scan, display dark
//   load         in   1          strobe capturing value/dp into pending buffer
//   value        in   4*DIGITS   packed hex digits, digit 0 in [3:0]
//   dp           in   DIGITS     decimal point per digit
//   segments     out  8          {dp, g..a}, active-high
//   digit_en     out  DIGITS     one-hot active-high digit select
//   frame_start  out  1          one-cycle pulse as the scan returns to digit 0
// -----------------------------------------------------------------------------
module sevensegment_scanner
    import sevseg_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned GUARD    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    output logic [7:0]            segments,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  frame_start
);

    localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CNT_W-1:0]     cnt_q,        cnt_d;
    logic [IDX_W-1:0]     idx_q,        idx_d;
    logic [4*DIGITS-1:0]  disp_val_q,   disp_val_d;
    logic [DIGITS-1:0]    disp_dp_q,    disp_dp_d;
    logic [4*DIGITS-1:0]  pend_val_q,   pend_val_d;
    logic [DIGITS-1:0]    pend_dp_q,    pend_dp_d;
    logic                 pend_valid_q, pend_valid_d;
    logic                 frame_start_q, frame_start_d;

    logic                 tick_s;
    logic                 wrap_s;
    logic                 active_s;
    logic                 blank_s;
    logic [3:0]           nib_s;
    logic [6:0]           glyph_s;
    logic [MAX_DIGITS-1:0] onehot_s;

    // Slot tick and frame wrap detection
    always_comb begin
        tick_s = enable && (cnt_q == CNT_W'(PRESCALE - 1));
        wrap_s = tick_s && (idx_q == IDX_W'(DIGITS - 1));
    end

    // Next-state for scan position, display and pending buffers
    always_comb begin
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        disp_val_d    = disp_val_q;
        disp_dp_d     = disp_dp_q;
        pend_val_d    = pend_val_q;
        pend_dp_d     = pend_dp_q;
        pend_valid_d  = pend_valid_q;
        frame_start_d = wrap_s;

        if (tick_s) begin
            cnt_d = '0;
            if (wrap_s) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else if (enable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        // Transfer reads the old pending value, so a coincident load below
        // lands in pend for the next frame and keeps pend_valid set.
        if (wrap_s && pend_valid_q) begin
            disp_val_d   = pend_val_q;
            disp_dp_d    = pend_dp_q;
            pend_valid_d = 1'b0;
        end else begin
            disp_val_d   = disp_val_q;
            disp_dp_d    = disp_dp_q;
        end

        if (load) begin
            pend_val_d   = value;
            pend_dp_d    = dp;
            pend_valid_d = 1'b1;
        end else begin
            pend_val_d   = pend_val_q;
            pend_dp_d    = pend_dp_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            disp_val_q    <= '0;
            disp_dp_q     <= '0;
            pend_val_q    <= '0;
            pend_dp_q     <= '0;
            pend_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            disp_val_q    <= disp_val_d;
            disp_dp_q     <= disp_dp_d;
            pend_val_q    <= pend_val_d;
            pend_dp_q     <= pend_dp_d;
            pend_valid_q  <= pend_valid_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Nibble of the digit currently being scanned
    always_comb begin
        nib_s = disp_val_q[{idx_q, 2'b00} +: 4];
    end

    sevensegmentdecoder u_dec (
        .hex (nib_s),
        .seg (glyph_s)
    );

`ifdef SEVSEG_BLANK_EN
    logic [4*DIGITS-1:0] upper_s;

    // Leading-zero detect: current and all higher nibbles zero, digit 0 exempt
    always_comb begin
        upper_s = disp_val_q >> {idx_q, 2'b00};
        if (idx_q != IDX_W'(0)) begin
            blank_s = (upper_s == '0);
        end else begin
            blank_s = 1'b0;
        end
    end
`else
    // Every digit shows its glyph, leading zeros included
    always_comb begin
        blank_s = 1'b0;
    end
`endif

    // Drive pins: enable gates the select directly so the display goes dark
    // in the same cycle enable drops; the segment bus is dark whenever no
    // digit is selected (reset, guard interval, scan disabled).
    always_comb begin
        onehot_s = onehot_idx(3'(idx_q));
        active_s = enable && (cnt_q >= CNT_W'(GUARD));
        segments = SEG_BLANK;
        digit_en = '0;
        if (active_s) begin
            digit_en               = onehot_s[DIGITS-1:0];
            segments[SEG_DP]       = disp_dp_q[idx_q];
            segments[SEG_G:SEG_A]  = blank_s ? 7'h00 : glyph_s;
        end else begin
            digit_en = '0;
            segments = SEG_BLANK;
        end
    end

    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_sevensegment_scanner.sv
// -----------------------------------------------------------------------------
// tb_sevensegment_scanner
// Scoreboard bench: a frame-position reference model pushes the expected
// pin values for every cycle; a monitor pops and compares on the falling edge.
// Directed scenarios add fixed-value checks on top of randomized traffic.
// -----------------------------------------------------------------------------
module tb_sevensegment_scanner;

    localparam int DIGITS   = 4;
    localparam int PRESCALE = 4;
    localparam int GUARD    = 1;
    localparam int FRAME    = DIGITS * PRESCALE;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                enable;
    logic                load;
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp;
    logic [7:0]          segments;
    logic [DIGITS-1:0]   digit_en;
    logic                frame_start;

    sevensegment_scanner #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .GUARD(GUARD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .load        (load),
        .value       (value),
        .dp          (dp),
        .segments    (segments),
        .digit_en    (digit_en),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef struct packed {
        logic [7:0]        seg;
        logic [DIGITS-1:0] den;
        logic              fs;
    } exp_t;

    exp_t sb[$];

    int                  m_pos = 0;   // cycle position within the frame
    logic [4*DIGITS-1:0] m_disp_v = '0, m_pend_v = '0;
    logic [DIGITS-1:0]   m_disp_dp = '0, m_pend_dp = '0;
    bit                  m_pend_ok = 0, m_fs = 0;

    always @(posedge clk) begin
        int   digit, off;
        bit   blank;
        exp_t e;
        if (!rst_n) begin
            m_pos = 0; m_disp_v = '0; m_disp_dp = '0;
            m_pend_v = '0; m_pend_dp = '0; m_pend_ok = 0; m_fs = 0;
        end else begin
            m_fs = 0;
            if (enable) begin
                if (m_pos == FRAME - 1) begin
                    m_fs = 1;
                    m_pos = 0;
                    if (m_pend_ok) begin
                        m_disp_v = m_pend_v; m_disp_dp = m_pend_dp; m_pend_ok = 0;
                    end
                end else begin
                    m_pos = m_pos + 1;
                end
            end
            if (load) begin
                m_pend_v = value; m_pend_dp = dp; m_pend_ok = 1;
            end
        end
        #2;  // pick up this cycle's enable, driven just after the edge
        digit = m_pos / PRESCALE;
        off   = m_pos % PRESCALE;
        blank = 0;
`ifdef SEVSEG_BLANK_EN
        blank = (digit > 0) && ((m_disp_v >> (4 * digit)) == 0);
`endif
        e.fs  = m_fs;
        e.den = '0;
        e.seg = 8'h00;
        if (enable && off >= GUARD) begin
            e.den = DIGITS'(1 << digit);
            e.seg = {m_disp_dp[digit], blank ? 7'h00 : glyph[(m_disp_v >> (4 * digit)) & 16'hF]};
        end
        sb.push_back(e);
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("segments", 32'(segments), 32'(e.seg));
            chk("digit_en", 32'(digit_en), 32'(e.den));
            chk("frame_start", 32'(frame_start), 32'(e.fs));
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_pos(input int p);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (m_pos == p) return;
        end
        chk("wait_pos_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_fs();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) return;
        end
        chk("wait_frame_start_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_den(input logic [DIGITS-1:0] want);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (digit_en === want) return;
        end
        chk("wait_digit_en_timeout", 32'd1, 32'd0);
    endtask

    task automatic pulse_load(input logic [4*DIGITS-1:0] v, input logic [DIGITS-1:0] d);
        load = 1'b1; value = v; dp = d;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] mask;
        rst_n = 1'b0; enable = 1'b0; load = 1'b0; value = '0; dp = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; enable = 1'b1;

        // idle scan after reset
        wait_den(4'b0001); chk("idle_digit0", 32'(segments), 32'h3F);
`ifdef SEVSEG_BLANK_EN
        wait_den(4'b0010); chk("idle_digit1", 32'(segments), 32'h00);
`else
        wait_den(4'b0010); chk("idle_digit1", 32'(segments), 32'h3F);
`endif
        wait_fs(); chk("frame_start_pulse", 32'(frame_start), 32'h1);

        // mid-frame load becomes visible after the wrap
        wait_pos(6); pulse_load(16'h12AF, 4'b0100);
        wait_fs();
        wait_den(4'b0001); chk("12AF_d0", 32'(segments), 32'h71);
        wait_den(4'b0010); chk("12AF_d1", 32'(segments), 32'h77);
        wait_den(4'b0100); chk("12AF_d2", 32'(segments), 32'hDB);
        wait_den(4'b1000); chk("12AF_d3", 32'(segments), 32'h06);

        // two loads in one frame: last wins
        wait_pos(2); pulse_load(16'h1111, 4'b0000);
        wait_pos(7); pulse_load(16'h2222, 4'b0000);
        wait_fs();
        wait_den(4'b0001); chk("lastwin_d0", 32'(segments), 32'h5B);
        wait_den(4'b1000); chk("lastwin_d3", 32'(segments), 32'h5B);

        // load on the wrap tick with 4444 pending
        wait_pos(5);  pulse_load(16'h4444, 4'b0000);
        wait_pos(15); pulse_load(16'h3333, 4'b0000);
        wait_den(4'b0001); chk("wrapload_f1", 32'(segments), 32'h66);
        wait_fs();
        wait_den(4'b0001); chk("wrapload_f2", 32'(segments), 32'h4F);

        // enable low mid-slot of digit 2
        wait_pos(9);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); chk("disabled_dark", 32'(digit_en), 32'h0);
            @(posedge clk); #1;
        end
        enable = 1'b1;
        @(negedge clk); chk("resume_digit2", 32'(digit_en), 32'h4);

        // one-cycle reset at digit 3
        wait_pos(13);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_segments", 32'(segments), 32'h0);
        chk("rst_digit_en", 32'(digit_en), 32'h0);
        chk("rst_frame_start", 32'(frame_start), 32'h0);
        wait_den(4'b0001); chk("rst_disp_cleared", 32'(segments), 32'h3F);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            case ($urandom_range(0, 3))
                0:       mask = 16'hFFFF;
                1:       mask = 16'h00FF;
                2:       mask = 16'h000F;
                default: mask = 16'h0F0F;
            endcase
            enable = ($urandom_range(0, 9) != 0);
            load   = ($urandom_range(0, 7) == 0);
            value  = 16'($urandom) & mask;
            dp     = 4'($urandom);
            rst_n  = ($urandom_range(0, 199) != 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; enable = 1'b1; load = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
